// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider with a start/busy/done handshake; one quotient bit per cycle.
// Define SIGNED_DIV_EN to build signed (truncating) division selected by sgn.
module seq_divider32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sgn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             dz
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_dz_pend;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_sub;
    logic             w_borrow;
    logic             w_accept;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    // Full WIDTH+1-bit partial remainder so divisors with the MSB set cannot wrap.
    assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
    assign w_sub    = {1'b0, w_shift} - {2'b00, r_div};
    assign w_borrow = w_sub[WIDTH+1];
    assign w_accept = (r_state == S_IDLE) && start && !done;
    assign w_b_zero = (B == '0);

`ifdef SIGNED_DIV_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = sgn && A[WIDTH-1];
    assign w_b_neg = sgn && B[WIDTH-1];
    assign w_mag_a = w_a_neg ? (~A + 1'b1) : A;
    assign w_mag_b = w_b_neg ? (~B + 1'b1) : B;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end
`else
    logic w_unused_sgn;

    assign w_unused_sgn = sgn;
    assign w_mag_a      = A;
    assign w_mag_b      = B;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_dz_pend <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Q         <= '0;
            R         <= '0;
            dz        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                        r_dz_pend <= w_b_zero;
                        r_div     <= w_mag_b;
                        // On divide-by-zero the raw dividend is kept for R.
                        r_dvd     <= w_b_zero ? A : w_mag_a;
                        r_state   <= w_b_zero ? S_FIN : S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_borrow) begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    end else begin
                        r_rem <= w_sub[WIDTH-1:0];
                        r_dvd <= {r_dvd[WIDTH-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (r_dz_pend) begin
                        Q <= '1;
                        R <= r_dvd;
                    end else begin
`ifdef SIGNED_DIV_EN
                        Q <= r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
                        R <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
`else
                        Q <= r_dvd;
                        R <= r_rem;
`endif
                    end
                    dz      <= r_dz_pend;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// Directed self-checking bench for seq_divider32 (WIDTH=32): latency, results, handshake, reset.
// Signed vectors are exercised when SIGNED_DIV_EN is defined; otherwise sgn=1 must act unsigned.
module tb_seq_divider32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        sgn;
    logic        busy;
    logic        done;
    logic [31:0] Q;
    logic [31:0] R;
    logic        dz;

    int checks = 0;
    int errors = 0;
    int lat;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .sgn   (sgn),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one operation; returns edges from accept to the edge after which done is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int n);
        @(negedge clk);
        A = a;
        B = b;
        sgn = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        sgn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_Q", Q, 32'd0);
        chk("rst_R", R, 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        rst_n = 1'b1;

        // 100 / 7
        run_op(32'd100, 32'd7, 1'b0, lat);
        chk("u_lat", 32'(lat), 32'd33);
        chk("u_Q", Q, 32'd14);
        chk("u_R", R, 32'd2);
        chk("u_dz", 32'(dz), 32'd0);
        chk("u_busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("u_done_pulse", 32'(done), 32'd0);
        chk("u_Q_hold", Q, 32'd14);

        // Divide by zero
        run_op(32'h1234_5678, 32'd0, 1'b0, lat);
        chk("dz_lat", 32'(lat), 32'd1);
        chk("dz_Q", Q, 32'hFFFF_FFFF);
        chk("dz_R", R, 32'h1234_5678);
        chk("dz_flag", 32'(dz), 32'd1);

        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        chk("max_lat", 32'(lat), 32'd33);
        chk("max_Q", Q, 32'hFFFF_FFFF);
        chk("max_R", R, 32'd0);
        chk("max_dz_clr", 32'(dz), 32'd0);

        run_op(32'd5, 32'd9, 1'b0, lat);
        chk("small_Q", Q, 32'd0);
        chk("small_R", R, 32'd5);

        run_op(32'd0, 32'd5, 1'b0, lat);
        chk("zero_lat", 32'(lat), 32'd33);
        chk("zero_Q", Q, 32'd0);
        chk("zero_R", R, 32'd0);

        // Divisor with MSB set: partial remainder must not wrap
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, lat);
        chk("bigdiv_Q", Q, 32'd1);
        chk("bigdiv_R", R, 32'd1);

        run_op(32'hDEAD_BEEF, 32'h0001_0000, 1'b0, lat);
        chk("shift_Q", Q, 32'h0000_DEAD);
        chk("shift_R", R, 32'h0000_BEEF);

        // Handshake: extra starts during the op and in the done cycle are ignored
        @(negedge clk);
        A = 32'd1000;
        B = 32'd10;
        sgn = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 100;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (c == 3 || c == 10) begin
                chk("hs_busy", 32'(busy), 32'd1);
                A = 32'd77;
                B = 32'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("hs_lat", 32'(lat), 32'd33);
        chk("hs_Q", Q, 32'd100);
        chk("hs_R", R, 32'd0);
        A = 32'd9;
        B = 32'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("hs_done_start_busy", 32'(busy), 32'd0);
        chk("hs_done_start_done", 32'(done), 32'd0);
        chk("hs_Q_kept", Q, 32'd100);
        run_op(32'd9, 32'd2, 1'b0, lat);
        chk("hs_next_lat", 32'(lat), 32'd33);
        chk("hs_next_Q", Q, 32'd4);
        chk("hs_next_R", R, 32'd1);

        // Reset mid-operation
        @(negedge clk);
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_Q", Q, 32'd0);
        chk("mrst_R", R, 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) lat++;
        end
        chk("mrst_no_done", 32'(lat), 32'd0);
        run_op(32'd100, 32'd7, 1'b0, lat);
        chk("mrst_re_lat", 32'(lat), 32'd33);
        chk("mrst_re_Q", Q, 32'd14);
        chk("mrst_re_R", R, 32'd2);

`ifdef SIGNED_DIV_EN
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
        chk("s_Q", Q, 32'hFFFF_FFFD);
        chk("s_R", R, 32'hFFFF_FFFF);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
        chk("s2_Q", Q, 32'hFFFF_FFFD);
        chk("s2_R", R, 32'd1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
        chk("sovf_Q", Q, 32'h8000_0000);
        chk("sovf_R", R, 32'd0);
        chk("sovf_dz", 32'(dz), 32'd0);
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, lat);
        chk("sdz_Q", Q, 32'hFFFF_FFFF);
        chk("sdz_R", R, 32'hFFFF_FFF9);
        chk("sdz_flag", 32'(dz), 32'd1);
`else
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
        chk("nosgn_Q", Q, 32'h7FFF_FFFC);
        chk("nosgn_R", R, 32'd1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
        chk("nosgn2_Q", Q, 32'd0);
        chk("nosgn2_R", R, 32'h8000_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
